// File: rtl/whiz_graphics_renderer.sv
// Background renderer: CPU-visible VRAM and LCD registers, streaming a
// 160x144 frame of 2-bit palette shades, one pixel per clock.
module whiz_graphics_renderer #(
    parameter int DEBUG_OUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [1:0]  pix_shade,
    output logic        render_complete,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for LCDEnable; frame registers latched on exit
    // RENDER | one pixel per clock, x fastest, (0,0)..(159,143)
    // DONE   | single cycle flagging render_complete
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_X = 8'd159;
    localparam logic [7:0] LAST_Y = 8'd143;

    localparam logic [15:0] ADDR_LCDC = 16'hFF40;
    localparam logic [15:0] ADDR_SCY  = 16'hFF42;
    localparam logic [15:0] ADDR_SCX  = 16'hFF43;
    localparam logic [15:0] ADDR_BGP  = 16'hFF47;

    state_t state, state_nxt;

    logic [7:0] vram [0:8191];

    logic [7:0] lcdc, scy, scx, bgp;
    logic       bg_en_lat, tile_sel_lat, map_sel_lat;
    logic [7:0] scy_lat, scx_lat, bgp_lat;
    logic [7:0] x, y;

    logic        vram_hit;
    logic [7:0]  rd_mux;
    logic        start;

    logic [7:0]  bx, by;
    logic [12:0] map_addr, row_addr;
    logic [7:0]  tile_num, plane0, plane1;
    logic [2:0]  bit_sel;
    logic [1:0]  colour, shade;

    // Trace hooks live outside the RTL; the parameter only keeps the interface stable.
    if (DEBUG_OUT != 0) begin : g_debug
    end

    assign vram_hit = (addr[15:13] == 3'b100);
    assign start    = (state == IDLE) && lcdc[7];

    // VRAM has no reset and no render-time lockout.
    always_ff @(posedge clk) begin
        if (we && vram_hit) begin
            vram[addr[12:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcdc <= 8'h11;
            scy  <= 8'h00;
            scx  <= 8'h00;
            bgp  <= 8'hE4;
        end else if (we) begin
            case (addr)
                ADDR_LCDC: lcdc <= wdata;
                ADDR_SCY:  scy  <= wdata;
                ADDR_SCX:  scx  <= wdata;
                ADDR_BGP:  bgp  <= wdata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'hFF;
        if (vram_hit) begin
            rd_mux = vram[addr[12:0]];
        end else begin
            case (addr)
                ADDR_LCDC: rd_mux = lcdc;
                ADDR_SCY:  rd_mux = scy;
                ADDR_SCX:  rd_mux = scx;
                ADDR_BGP:  rd_mux = bgp;
                default:   rd_mux = 8'hFF;
            endcase
        end
    end

    // Sampled before this edge's write lands, so a same-cycle write reads old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bg_en_lat    <= 1'b0;
            tile_sel_lat <= 1'b0;
            map_sel_lat  <= 1'b0;
            scy_lat      <= 8'h00;
            scx_lat      <= 8'h00;
            bgp_lat      <= 8'h00;
            x            <= 8'h00;
            y            <= 8'h00;
        end else if (start) begin
            bg_en_lat    <= lcdc[0];
            tile_sel_lat <= lcdc[4];
            map_sel_lat  <= lcdc[3];
            scy_lat      <= scy;
            scx_lat      <= scx;
            bgp_lat      <= bgp;
            x            <= 8'h00;
            y            <= 8'h00;
        end else if (state == RENDER) begin
            if (x == LAST_X) begin
                x <= 8'h00;
                y <= y + 8'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    assign bx       = x + scx_lat;
    assign by       = y + scy_lat;
    assign map_addr = {2'b11, map_sel_lat, by[7:3], bx[7:3]};
    assign tile_num = vram[map_addr];

    // Signed mode: 0..127 map to 9000.., 128..255 to 8800..8FF0.
    assign row_addr = tile_sel_lat ? {1'b0, tile_num, by[2:0], 1'b0}
                                   : {~tile_num[7], tile_num, by[2:0], 1'b0};
    assign plane0   = vram[row_addr];
    assign plane1   = vram[row_addr | 13'd1];
    assign bit_sel  = ~bx[2:0];
    assign colour   = {plane1[bit_sel], plane0[bit_sel]};

    always_comb begin
        shade = bgp_lat[1:0];
        case (colour)
            2'd0: shade = bgp_lat[1:0];
            2'd1: shade = bgp_lat[3:2];
            2'd2: shade = bgp_lat[5:4];
            2'd3: shade = bgp_lat[7:6];
            default: shade = bgp_lat[1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pix_valid       = 1'b0;
        pix_x           = 8'h00;
        pix_y           = 8'h00;
        pix_shade       = 2'd0;
        render_complete = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                if (lcdc[7]) begin
                    state_nxt = RENDER;
                end
            end
            RENDER: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                pix_x     = x;
                pix_y     = y;
                pix_shade = bg_en_lat ? shade : 2'd0;
                if (!lcdc[7]) begin
                    state_nxt = IDLE;
                end else if ((x == LAST_X) && (y == LAST_Y)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                render_complete = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_whiz_graphics_renderer.sv
// Directed bench for whiz_graphics_renderer: register map, full-frame timing,
// tile decode, palette, scrolling with wrap, signed tile addressing, abort, reset.
module tb_whiz_graphics_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [1:0]  pix_shade;
    logic        render_complete;
    logic        busy;

    whiz_graphics_renderer #(.DEBUG_OUT(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .addr            (addr),
        .wdata           (wdata),
        .we              (we),
        .re              (re),
        .rdata           (rdata),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_shade       (pix_shade),
        .render_complete (render_complete),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int first_cyc = 0;
    int frame_pix = 0;
    int pv_total  = 0;
    int rc_cnt    = 0;
    int fb [0:143][0:159];

    always @(posedge clk) cyc++;

    // Frame capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (pix_valid && pix_y < 8'd144 && pix_x < 8'd160) begin
            fb[pix_y][pix_x] = int'(pix_shade);
            if (pix_x == 8'd0 && pix_y == 8'd0) begin
                first_cyc = cyc;
                frame_pix = 1;
            end else begin
                frame_pix++;
            end
            pv_total++;
        end
        if (render_complete) rc_cnt++;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
        d    = rdata;
    endtask

    task automatic clear_fb(input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < 160; c++)
                fb[r][c] = -1;
    endtask

    task automatic wait_rc(output int c);
        c = -1;
        for (int k = 0; k < 25000; k++) begin
            @(negedge clk);
            if (render_complete) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check_val("rc_timeout", 0, 1);
    endtask

    // Render rows 0..row-1 then disable the LCD again.
    task automatic run_rows(input logic [7:0] lcdc_val, input logic [7:0] row);
        bit seen;
        seen = 1'b0;
        bus_wr(16'hFF40, lcdc_val);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (pix_valid && pix_y == row) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("row_timeout", 0, 1);
        bus_wr(16'hFF40, 8'h11);
        repeat (3) @(negedge clk);
    endtask

    // Row 3 of tile 2 placed at map (0,0) and (1,0), blank beyond.
    function automatic int pat3(input int i);
        int m;
        m = i % 8;
        if (i >= 16) return 0;
        if (m < 3) return 1;
        if (m == 3) return 3;
        return 0;
    endfunction

    int exp_chk[8]   = '{3, 3, 3, 3, 0, 0, 0, 0};
    int exp_grad[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    int exp_gradi[8] = '{3, 3, 2, 2, 1, 1, 0, 0};

    initial begin
        logic [7:0] rd;
        int rc_a, rc_b, rc0, pv0;
        bit seen;

        reset = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;
        we    = 1'b0;
        re    = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_rdata", int'(rdata), 0);
        check_val("rst_pix_valid", int'(pix_valid), 0);
        check_val("rst_rc", int'(render_complete), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_shade", int'(pix_shade), 0);
        reset = 1'b1;
        @(negedge clk);

        bus_rd(16'hFF40, rd); check_val("rd_lcdc", int'(rd), 8'h11);
        bus_rd(16'hFF47, rd); check_val("rd_bgp", int'(rd), 8'hE4);
        bus_rd(16'hFF42, rd); check_val("rd_scy", int'(rd), 0);
        bus_rd(16'hFF00, rd); check_val("rd_unmapped", int'(rd), 8'hFF);
        bus_rd(16'h7FFF, rd); check_val("rd_below_vram", int'(rd), 8'hFF);
        bus_wr(16'hFF43, 8'h5A);
        bus_rd(16'hFF43, rd); check_val("rd_scx_wr", int'(rd), 8'h5A);
        bus_wr(16'hFF43, 8'h00);
        bus_wr(16'hFF41, 8'h77);
        bus_rd(16'hFF41, rd); check_val("rd_ff41_ignored", int'(rd), 8'hFF);

        addr = 16'hFF42; wdata = 8'h33; we = 1'b1; re = 1'b1;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        check_val("rw_same_cycle_old", int'(rdata), 0);
        bus_rd(16'hFF42, rd); check_val("rw_same_cycle_new", int'(rd), 8'h33);
        bus_wr(16'hFF42, 8'h00);

        for (int i = 0; i < 16; i++) begin
            bus_wr(16'(16'h8000 + i), 8'h00);
            bus_wr(16'(16'h9000 + i), 8'h00);
        end
        for (int i = 0; i < 1024; i++) bus_wr(16'(16'h9800 + i), 8'h00);

        addr = 16'h8000; wdata = 8'hA5; we = 1'b1; re = 1'b1;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        check_val("rw_vram_old", int'(rdata), 0);
        bus_rd(16'h8000, rd); check_val("rw_vram_new", int'(rd), 8'hA5);
        bus_wr(16'h8000, 8'h00);

        check_val("idle_no_pixels", pv_total, 0);

        // Tile 1 checkerboard, tile 4 gradient, tile 2 bar/line.
        for (int r = 0; r < 8; r++) begin
            bus_wr(16'(16'h8010 + 2 * r), (r < 4) ? 8'hF0 : 8'h0F);
            bus_wr(16'(16'h8011 + 2 * r), (r < 4) ? 8'hF0 : 8'h0F);
            bus_wr(16'(16'h8040 + 2 * r), (r == 0) ? 8'h33 : 8'h00);
            bus_wr(16'(16'h8041 + 2 * r), (r == 0) ? 8'h0F : 8'h00);
            bus_wr(16'(16'h8020 + 2 * r), (r == 3) ? 8'hF0 : 8'h00);
            bus_wr(16'(16'h8021 + 2 * r), 8'h10);
        end
        bus_wr(16'h9800, 8'h01);
        bus_wr(16'h9801, 8'h04);

        clear_fb(144);
        bus_wr(16'hFF40, 8'h91);
        wait_rc(rc_a);
        bus_wr(16'hFF47, 8'h1B);
        check_val("frame_latency", rc_a - first_cyc, 23040);
        check_val("frame_pixels", frame_pix, 23040);
        for (int c = 0; c < 8; c++) check_val("checker_row0", fb[0][c], exp_chk[c]);
        check_val("checker_row4_c0", fb[4][0], 0);
        check_val("checker_row4_c4", fb[4][4], 3);
        for (int c = 0; c < 8; c++) check_val("gradient", fb[0][8 + c], exp_grad[c]);
        check_val("last_pixel", fb[143][159], 0);

        wait_rc(rc_b);
        bus_wr(16'hFF40, 8'h11);
        check_val("restart_gap", first_cyc - rc_a, 2);
        for (int c = 0; c < 8; c++) check_val("gradient_bgp1b", fb[0][8 + c], exp_gradi[c]);
        check_val("checker_bgp1b_c0", fb[0][0], 0);
        check_val("checker_bgp1b_c4", fb[0][4], 3);
        bus_wr(16'hFF47, 8'hE4);

        bus_wr(16'h9800, 8'h02);
        bus_wr(16'h9801, 8'h02);
        for (int k = 0; k < 8; k++) begin
            clear_fb(8);
            bus_wr(16'hFF43, 8'(k));
            run_rows(8'h91, 8'd4);
            for (int xx = 0; xx < 16; xx++) check_val("scroll_row3", fb[3][xx], pat3(xx + k));
        end

        // SCX=248 reaches map column 31, SCY=253 reaches map row 31.
        bus_wr(16'h981F, 8'h02);
        bus_wr(16'h9BFF, 8'h01);
        bus_wr(16'hFF43, 8'hF8);
        bus_wr(16'hFF42, 8'hFD);
        clear_fb(8);
        run_rows(8'h91, 8'd7);
        for (int xx = 0; xx < 24; xx++) check_val("wrap_row6", fb[6][xx], pat3(xx % 8));
        check_val("wrap_y_c3", fb[0][3], 0);
        check_val("wrap_y_c4", fb[0][4], 3);
        check_val("wrap_y_c8", fb[0][8], 0);
        bus_wr(16'hFF43, 8'h00);
        bus_wr(16'hFF42, 8'h00);

        bus_wr(16'h8FF0, 8'h80);
        bus_wr(16'h8FF1, 8'h80);
        bus_wr(16'h9010, 8'hC0);
        bus_wr(16'h9011, 8'h00);
        bus_wr(16'h8800, 8'h00);
        bus_wr(16'h8801, 8'hF0);
        bus_wr(16'h9800, 8'hFF);
        bus_wr(16'h9801, 8'h01);
        bus_wr(16'h9802, 8'h80);
        bus_wr(16'h9803, 8'h00);
        clear_fb(8);
        run_rows(8'h81, 8'd1);
        check_val("signed_m1_c0", fb[0][0], 3);
        check_val("signed_m1_c1", fb[0][1], 0);
        check_val("signed_p1_c0", fb[0][8], 1);
        check_val("signed_p1_c1", fb[0][9], 1);
        check_val("signed_p1_c2", fb[0][10], 0);
        check_val("signed_80_c0", fb[0][16], 2);
        check_val("signed_80_c3", fb[0][19], 2);
        check_val("signed_80_c4", fb[0][20], 0);
        check_val("signed_00", fb[0][24], 0);

        clear_fb(8);
        run_rows(8'h90, 8'd1);
        check_val("bg_off_c0", fb[0][0], 0);
        check_val("bg_off_c16", fb[0][16], 0);

        bus_wr(16'h9C00, 8'h04);
        bus_wr(16'h9C01, 8'h00);
        clear_fb(8);
        run_rows(8'h99, 8'd1);
        check_val("map1_c2", fb[0][2], 1);
        check_val("map1_c7", fb[0][7], 3);
        check_val("map1_c8", fb[0][8], 0);

        // Abort at pixel index 1000 = (40,6).
        bus_wr(16'hFF40, 8'h91);
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 8'd40 && pix_y == 8'd6) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("abort_timeout", 0, 1);
        rc0 = rc_cnt;
        bus_wr(16'hFF40, 8'h11);
        repeat (4) @(negedge clk);
        check_val("abort_pix_valid", int'(pix_valid), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_pixels", frame_pix, 1002);
        pv0 = pv_total;
        repeat (100) @(negedge clk);
        check_val("abort_no_rc", rc_cnt, rc0);
        check_val("abort_no_more_pix", pv_total, pv0);

        bus_wr(16'hFF43, 8'h07);
        bus_wr(16'hFF40, 8'h91);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 8'd20) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("midframe_timeout", 0, 1);
        bus_rd(16'hFF47, rd);
        reset = 1'b0;
        #1;
        check_val("midrst_pix_valid", int'(pix_valid), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_pix_x", int'(pix_x), 0);
        check_val("midrst_rdata", int'(rdata), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_rd(16'hFF40, rd); check_val("midrst_lcdc", int'(rd), 8'h11);
        bus_rd(16'hFF43, rd); check_val("midrst_scx", int'(rd), 0);
        bus_rd(16'h8010, rd); check_val("vram_kept", int'(rd), 8'hF0);
        check_val("midrst_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
